// File: rtl/csr_unit.sv
// Machine-mode CSR unit: decodes CSR addresses and performs atomic CSRRW/CSRRS/CSRRC.
// Also keeps the 64-bit mcycle/minstret counters and the trap state (mepc, mcause, mstatus).
module csr_unit #(
    parameter int unsigned          XLEN      = 32,
    parameter logic [XLEN-1:0]      RESET_VEC = '0,
    parameter logic [XLEN-1:0]      HART_ID   = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      csr_op,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_wdata,
    input  logic            csr_src_zero,
    output logic [XLEN-1:0] csr_rdata,
    output logic            csr_illegal,
    input  logic            instret,
    input  logic            trap_en,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_pc,
    input  logic            mret,
    output logic [XLEN-1:0] mtvec_o,
    output logic [XLEN-1:0] mepc_o,
    output logic            mie_o
);

    localparam logic [1:0]      OP_NONE   = 2'b00;
    localparam logic [1:0]      OP_RW     = 2'b01;
    localparam logic [1:0]      OP_RS     = 2'b10;
    localparam logic [XLEN-1:0] ALIGN_MSK = ~{{(XLEN-2){1'b0}}, 2'b11};

    logic            mie_q, mpie_q;
    logic [XLEN-1:0] mtvec_q, mscratch_q, mepc_q, mcause_q;
    logic [63:0]     mcycle_q, minstret_q;

    logic [XLEN-1:0] old_val, new_val;
    logic            mapped, we, wr;

    // Access protocol: an access is presented whenever csr_op != 0. There is no
    // backpressure; the old value and csr_illegal are combinational and the write
    // commits on the next rising edge.
    always_comb begin
        old_val = '0;
        mapped  = 1'b1;
        case (csr_addr)
            12'h300: begin
                old_val[3] = mie_q;
                old_val[7] = mpie_q;
            end
            12'h305:          old_val = mtvec_q;
            12'h340:          old_val = mscratch_q;
            12'h341:          old_val = mepc_q;
            12'h342:          old_val = mcause_q;
            12'hB00, 12'hC00: old_val = mcycle_q[31:0];
            12'hB80, 12'hC80: old_val = mcycle_q[63:32];
            12'hB02, 12'hC02: old_val = minstret_q[31:0];
            12'hB82, 12'hC82: old_val = minstret_q[63:32];
            12'hF14:          old_val = HART_ID;
            default:          mapped  = 1'b0;
        endcase
    end

    always_comb begin
        case (csr_op)
            OP_RW:   new_val = csr_wdata;
            OP_RS:   new_val = old_val | csr_wdata;
            default: new_val = old_val & ~csr_wdata;
        endcase
    end

    assign we          = (csr_op == OP_RW) || ((csr_op != OP_NONE) && !csr_src_zero);
    assign csr_illegal = (csr_op != OP_NONE) && (!mapped || (we && (csr_addr[11:10] == 2'b11)));
    assign wr          = we && !csr_illegal;
    assign csr_rdata   = ((csr_op != OP_NONE) && !csr_illegal) ? old_val : '0;

    logic wr_mstatus, wr_mtvec, wr_mscratch, wr_mepc, wr_mcause;
    logic wr_cyc_lo, wr_cyc_hi, wr_ins_lo, wr_ins_hi;

    assign wr_mstatus  = wr && (csr_addr == 12'h300);
    assign wr_mtvec    = wr && (csr_addr == 12'h305);
    assign wr_mscratch = wr && (csr_addr == 12'h340);
    assign wr_mepc     = wr && (csr_addr == 12'h341);
    assign wr_mcause   = wr && (csr_addr == 12'h342);
    assign wr_cyc_lo   = wr && (csr_addr == 12'hB00);
    assign wr_cyc_hi   = wr && (csr_addr == 12'hB80);
    assign wr_ins_lo   = wr && (csr_addr == 12'hB02);
    assign wr_ins_hi   = wr && (csr_addr == 12'hB82);

    // Priority for MIE/MPIE: trap entry, then mret, then a CSR write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mie_q  <= 1'b0;
            mpie_q <= 1'b0;
        end else if (trap_en) begin
            mpie_q <= mie_q;
            mie_q  <= 1'b0;
        end else if (mret) begin
            mie_q  <= mpie_q;
            mpie_q <= 1'b1;
        end else if (wr_mstatus) begin
            mie_q  <= new_val[3];
            mpie_q <= new_val[7];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtvec_q    <= RESET_VEC & ALIGN_MSK;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
        end else begin
            if (wr_mtvec)    mtvec_q    <= new_val & ALIGN_MSK;
            if (wr_mscratch) mscratch_q <= new_val;
            if (trap_en) begin
                mepc_q   <= trap_pc & ALIGN_MSK;
                mcause_q <= trap_cause;
            end else begin
                if (wr_mepc)   mepc_q   <= new_val & ALIGN_MSK;
                if (wr_mcause) mcause_q <= new_val;
            end
        end
    end

    // A write to either counter half replaces it and suppresses that cycle's increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            if (wr_cyc_lo)      mcycle_q[31:0]  <= new_val;
            else if (wr_cyc_hi) mcycle_q[63:32] <= new_val;
            else                mcycle_q        <= mcycle_q + 64'd1;

            if (wr_ins_lo)      minstret_q[31:0]  <= new_val;
            else if (wr_ins_hi) minstret_q[63:32] <= new_val;
            else if (instret)   minstret_q        <= minstret_q + 64'd1;
        end
    end

    assign mtvec_o = mtvec_q;
    assign mepc_o  = mepc_q;
    assign mie_o   = mie_q;

endmodule

// File: tb/tb_csr_unit.sv
// Bench for csr_unit: randomized and directed CSR traffic checked by a scoreboard
// against a behavioural model of the CSR file.
module tb_csr_unit;

    localparam logic [31:0] RESET_VEC = 32'h0000_0100;
    localparam int          EW        = 98;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  csr_op = '0;
    logic [11:0] csr_addr = '0;
    logic [31:0] csr_wdata = '0;
    logic        csr_src_zero = 1'b0;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        instret = 1'b0;
    logic        trap_en = 1'b0;
    logic [31:0] trap_cause = '0;
    logic [31:0] trap_pc = '0;
    logic        mret = 1'b0;
    logic [31:0] mtvec_o, mepc_o;
    logic        mie_o;

    always #5 clk = ~clk;

    csr_unit #(.XLEN(32), .RESET_VEC(RESET_VEC), .HART_ID(32'h0)) dut (
        .clk(clk), .rst(rst), .csr_op(csr_op), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
        .csr_src_zero(csr_src_zero), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
        .instret(instret), .trap_en(trap_en), .trap_cause(trap_cause), .trap_pc(trap_pc),
        .mret(mret), .mtvec_o(mtvec_o), .mepc_o(mepc_o), .mie_o(mie_o)
    );

    // Reference model state
    logic        m_mie, m_mpie;
    logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause;
    logic [63:0] m_mcycle, m_minstret;

    logic [EW-1:0] exp_q[$];
    logic          mon_en = 1'b0;
    int            checks = 0;
    int            failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mie = 0; m_mpie = 0;
        m_mtvec = RESET_VEC & ~32'd3;
        m_mscratch = 0; m_mepc = 0; m_mcause = 0;
        m_mcycle = 0; m_minstret = 0;
    endtask

    function automatic void model_read(input logic [11:0] a, output logic [31:0] v, output logic ok);
        ok = 1'b1;
        v  = '0;
        case (a)
            12'h300:          v = (m_mie ? 32'h8 : 32'h0) | (m_mpie ? 32'h80 : 32'h0);
            12'h305:          v = m_mtvec;
            12'h340:          v = m_mscratch;
            12'h341:          v = m_mepc;
            12'h342:          v = m_mcause;
            12'hB00, 12'hC00: v = m_mcycle[31:0];
            12'hB80, 12'hC80: v = m_mcycle[63:32];
            12'hB02, 12'hC02: v = m_minstret[31:0];
            12'hB82, 12'hC82: v = m_minstret[63:32];
            12'hF14:          v = 32'h0;
            default:          ok = 1'b0;
        endcase
    endfunction

    // Drive one cycle of inputs, push the expected response, advance the model by one edge.
    task automatic apply(input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd,
                         input logic sz, input logic ir, input logic te, input logic [31:0] tc,
                         input logic [31:0] tp, input logic mr);
        logic [31:0] old, nv, rd;
        logic        ok, we, ill, wr, cyc_w, ins_w;
        logic        n_mie, n_mpie;
        csr_op = op; csr_addr = a; csr_wdata = wd; csr_src_zero = sz;
        instret = ir; trap_en = te; trap_cause = tc; trap_pc = tp; mret = mr;
        model_read(a, old, ok);
        we  = (op == 2'b01) || (op != 2'b00 && !sz);
        ill = (op != 2'b00) && (!ok || (we && a[11:10] == 2'b11));
        rd  = (op != 2'b00 && !ill) ? old : 32'h0;
        exp_q.push_back({rd, ill, m_mtvec, m_mepc, m_mie});
        mon_en = 1'b1;
        nv = (op == 2'b01) ? wd : (op == 2'b10) ? (old | wd) : (old & ~wd);
        wr = we && !ill;
        n_mie = m_mie; n_mpie = m_mpie;
        cyc_w = wr && (a == 12'hB00 || a == 12'hB80);
        ins_w = wr && (a == 12'hB02 || a == 12'hB82);
        if (wr) begin
            case (a)
                12'h300: begin n_mie = nv[3]; n_mpie = nv[7]; end
                12'h305: m_mtvec = nv & ~32'd3;
                12'h340: m_mscratch = nv;
                12'h341: if (!te) m_mepc = nv & ~32'd3;
                12'h342: if (!te) m_mcause = nv;
                12'hB00: m_mcycle = {m_mcycle[63:32], nv};
                12'hB80: m_mcycle = {nv, m_mcycle[31:0]};
                12'hB02: m_minstret = {m_minstret[63:32], nv};
                12'hB82: m_minstret = {nv, m_minstret[31:0]};
                default: ;
            endcase
        end
        if (!cyc_w) m_mcycle = m_mcycle + 64'd1;
        if (!ins_w && ir) m_minstret = m_minstret + 64'd1;
        if (te) begin
            m_mepc = tp & ~32'd3;
            m_mcause = tc;
            n_mpie = m_mie;
            n_mie = 1'b0;
        end else if (mr) begin
            n_mie = m_mpie;
            n_mpie = 1'b1;
        end
        m_mie = n_mie; m_mpie = n_mpie;
    endtask

    task automatic step();
        @(posedge clk); #1;
        mon_en = 1'b0;
    endtask

    task automatic op_cyc(input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd, input logic sz);
        apply(op, a, wd, sz, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        step();
    endtask

    // Same as op_cyc but also compares rdata/illegal against literal values.
    task automatic op_lit(input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd,
                          input logic sz, input logic [31:0] lit, input logic lit_ill, input string name);
        apply(op, a, wd, sz, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        #2;
        check({name, "_rdata"}, csr_rdata, lit);
        check({name, "_illegal"}, {31'b0, csr_illegal}, {31'b0, lit_ill});
        step();
    endtask

    // Monitor: pops one expectation per presented cycle
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (mon_en) begin
            if (exp_q.size() == 0) begin
                check("queue_underflow", 32'h1, 32'h0);
            end else begin
                e = exp_q.pop_front();
                check("rdata", csr_rdata, e[97:66]);
                check("illegal", {31'b0, csr_illegal}, {31'b0, e[65]});
                check("mtvec_o", mtvec_o, e[64:33]);
                check("mepc_o", mepc_o, e[32:1]);
                check("mie_o", {31'b0, mie_o}, {31'b0, e[0]});
            end
        end
    end

    initial begin
        #500000;
        check("timeout", 32'h1, 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    logic [11:0] addr_tab [17] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'hB00, 12'hB80,
                                   12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'hF14,
                                   12'h7C0, 12'h301, 12'hB01};

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Basic read/write and reset values
        op_lit(2'b01, 12'h340, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0, "mscratch_old");
        op_lit(2'b10, 12'h340, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, "mscratch_new");
        op_lit(2'b10, 12'h305, 32'h0, 1'b1, 32'h100, 1'b0, "mtvec_reset");
        op_lit(2'b10, 12'hF14, 32'h0, 1'b1, 32'h0, 1'b0, "mhartid");

        // mstatus WARL
        op_lit(2'b10, 12'h300, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0, "mstatus_rs_old");
        op_lit(2'b10, 12'h300, 32'h0, 1'b1, 32'h88, 1'b0, "mstatus_set");
        op_lit(2'b11, 12'h300, 32'h8, 1'b0, 32'h88, 1'b0, "mstatus_rc_old");
        op_lit(2'b10, 12'h300, 32'h0, 1'b1, 32'h80, 1'b0, "mstatus_clr");

        // Illegal accesses
        op_lit(2'b01, 12'hC00, 32'h5, 1'b0, 32'h0, 1'b1, "ro_write");
        op_cyc(2'b10, 12'hC00, 32'h0, 1'b1);
        op_lit(2'b11, 12'hC80, 32'h1, 1'b0, 32'h0, 1'b1, "ro_clear");
        op_lit(2'b01, 12'h7C0, 32'h1, 1'b0, 32'h0, 1'b1, "unmapped");
        op_cyc(2'b10, 12'hB00, 32'h0, 1'b1);

        // mcycle 64-bit wrap
        op_cyc(2'b01, 12'hB00, 32'hFFFF_FFFE, 1'b0);
        op_cyc(2'b01, 12'hB80, 32'hFFFF_FFFF, 1'b0);
        repeat (3) op_cyc(2'b00, 12'h0, 32'h0, 1'b0);
        op_lit(2'b10, 12'hB00, 32'h0, 1'b1, 32'h1, 1'b0, "wrap_lo");
        op_lit(2'b10, 12'hB80, 32'h0, 1'b1, 32'h0, 1'b0, "wrap_hi");

        // Trap entry with a same-cycle mepc write, then mret
        op_cyc(2'b01, 12'h300, 32'h8, 1'b0);
        apply(2'b01, 12'h341, 32'h5555_5554, 1'b0, 1'b1, 1'b1, 32'h8000_0007, 32'h0000_1237, 1'b0);
        step();
        op_lit(2'b10, 12'h341, 32'h0, 1'b1, 32'h1234, 1'b0, "trap_mepc");
        op_lit(2'b10, 12'h342, 32'h0, 1'b1, 32'h8000_0007, 1'b0, "trap_mcause");
        op_lit(2'b10, 12'h300, 32'h0, 1'b1, 32'h80, 1'b0, "trap_mstatus");
        apply(2'b00, 12'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        step();
        op_lit(2'b10, 12'h300, 32'h0, 1'b1, 32'h88, 1'b0, "mret_mstatus");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [1:0] op;
            op = 2'($urandom_range(0, 3));
            apply(op, addr_tab[$urandom_range(0, 16)], $urandom(), ($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0), $urandom(), $urandom(),
                  ($urandom_range(0, 14) == 0));
            step();
        end

        // Asynchronous reset in the middle of a write with instret high
        op_cyc(2'b01, 12'h341, 32'h0000_0ABC, 1'b0);
        op_cyc(2'b01, 12'h340, 32'h1, 1'b0);
        op_cyc(2'b01, 12'h300, 32'h8, 1'b0);
        repeat (2) @(negedge clk);
        csr_op = 2'b01; csr_addr = 12'h340; csr_wdata = 32'h1234_5678; csr_src_zero = 1'b0;
        instret = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("rst_mie", {31'b0, mie_o}, 32'h0);
        check("rst_mtvec", mtvec_o, RESET_VEC & ~32'd3);
        check("rst_mepc", mepc_o, 32'h0);
        check("rst_rdata", csr_rdata, 32'h0);
        @(posedge clk); #1;
        csr_op = '0; csr_addr = '0; csr_wdata = '0; instret = 1'b0;
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        op_lit(2'b10, 12'hB00, 32'h0, 1'b1, 32'h0, 1'b0, "post_rst_mcycle0");
        op_lit(2'b10, 12'hB00, 32'h0, 1'b1, 32'h1, 1'b0, "post_rst_mcycle1");
        op_lit(2'b10, 12'h340, 32'h0, 1'b1, 32'h0, 1'b0, "post_rst_mscratch");
        op_lit(2'b10, 12'hB02, 32'h0, 1'b1, 32'h0, 1'b0, "post_rst_minstret");
        op_lit(2'b10, 12'h300, 32'h0, 1'b1, 32'h0, 1'b0, "post_rst_mstatus");

        @(negedge clk);
        check("queue_drained", exp_q.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
